// File: rtl/msk_rnd_pkg.sv
// msk_rnd_pkg: shared sizing helpers and default randomness word width for the masked core
package msk_rnd_pkg;
    function automatic int f_ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction
    function automatic int f_clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r = r + 1;
        return r;
    endfunction
    localparam int HPC2RND = 1;
    localparam int RND_LANES = 20;
    localparam int RND_BUS0_N = 9;
    localparam int RND_BUS2_N = 3;
    localparam int RND_BUS3_N = 4;
    localparam int RND_BUS4_N = 18;
    localparam int OUT_W_DEF = RND_LANES * (RND_BUS0_N + RND_BUS2_N + RND_BUS3_N + RND_BUS4_N) * HPC2RND;
endpackage

// File: rtl/msk_rnd_fifo.sv
// msk_rnd_fifo: register FIFO of complete randomness words with flush and level output
module msk_rnd_fifo
    import msk_rnd_pkg::*;
#(
    parameter int W = 680,
    parameter int DEPTH = 2,
    localparam int LW = f_clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [LW-1:0] level,
    output logic [W-1:0]  head
);
    localparam int PW = DEPTH > 1 ? f_clog2(DEPTH) : 1;
    logic [W-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction
    assign do_pop = pop && level != '0;
    assign do_push = push && level != LW'(DEPTH);
    assign head = mem[rd_ptr];
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr <= nxt(wr_ptr);
            end
            if (do_pop) rd_ptr <= nxt(rd_ptr);
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end
endmodule

// File: rtl/msk_rnd_gearbox.sv
// msk_rnd_gearbox: packs PRNG chunks into fresh single-use randomness words for the masked core
module msk_rnd_gearbox
    import msk_rnd_pkg::*;
#(
    parameter int IN_W = 128,
    parameter int OUT_W = OUT_W_DEF,
    parameter int DEPTH = 2,
    localparam int LW = f_clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_rnd,
    output logic [LW-1:0]    level,
    output logic             rnd_underflow
);
    localparam int K = f_ceil_div(OUT_W, IN_W);
    localparam int CW = K > 1 ? f_clog2(K) : 1;
    logic [CW-1:0] chunk_cnt;
    logic [OUT_W-1:0] word, head;
    logic last, accept, push, pop;
    assign last = chunk_cnt == CW'(K - 1);
    assign in_ready = flush || !(last && level == LW'(DEPTH));
    assign accept = in_valid && in_ready && !flush;
    assign push = accept && last;
    assign pop = out_ready && out_valid;
    assign out_valid = level != '0;
    assign out_rnd = out_valid ? head : '0;
    // the final chunk is never stored; its bits above OUT_W fall off in the cast
    if (K > 1) begin : g_pack
        logic [(K-1)*IN_W-1:0] pack;
        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) pack <= '0;
            else if (accept && !last) pack[chunk_cnt*IN_W +: IN_W] <= in_data;
        end
        assign word = OUT_W'({in_data, pack});
    end else begin : g_nopack
        assign word = OUT_W'(in_data);
    end
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            chunk_cnt <= '0;
            rnd_underflow <= 1'b0;
        end else if (flush) begin
            chunk_cnt <= '0;
            rnd_underflow <= 1'b0;
        end else begin
            if (accept) chunk_cnt <= last ? '0 : chunk_cnt + 1'b1;
            if (out_ready && !out_valid) rnd_underflow <= 1'b1;
        end
    end
    msk_rnd_fifo #(.W(OUT_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (word),
        .level (level),
        .head  (head)
    );
endmodule

// File: tb/tb_msk_rnd_gearbox.sv
// tb_msk_rnd_gearbox: table vectors, corner sequences and a queue-based reference model
module tb_msk_rnd_gearbox;
    localparam int IN_W = 128;
    localparam int OUT_W = 680;
    localparam int DEPTH = 2;
    localparam int K = 6;
    localparam int LW = 2;
    logic clk, nrst, in_valid, in_ready, flush, out_valid, out_ready, rnd_underflow;
    logic [IN_W-1:0] in_data;
    logic [OUT_W-1:0] out_rnd;
    logic [LW-1:0] level;
    msk_rnd_gearbox #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .nrst          (nrst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_rnd       (out_rnd),
        .level         (level),
        .rnd_underflow (rnd_underflow)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    typedef struct {
        bit v;
        logic [IN_W-1:0] d;
        bit fl;
        bit rdy;
        bit e_ir;
        bit e_ov;
        int e_lvl;
        bit e_unf;
    } vec_t;
    vec_t tbl[$];
    int n_checks = 0;
    int n_errors = 0;
    logic [IN_W-1:0] m_chunks[$];
    logic [OUT_W-1:0] m_words[$];
    bit m_unf = 0;
    task automatic chk(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    function automatic logic [OUT_W-1:0] build_word();
        logic [K*IN_W-1:0] w;
        w = '0;
        for (int j = 0; j < K; j++) w[j*IN_W +: IN_W] = m_chunks[j];
        return w[OUT_W-1:0];
    endfunction
    function automatic bit m_ready();
        return flush || !(m_chunks.size() == K - 1 && m_words.size() == DEPTH);
    endfunction
    task automatic check_model();
        chk("m_in_ready", in_ready, m_ready());
        chk("m_out_valid", out_valid, m_words.size() != 0);
        chk("m_level", level, m_words.size());
        chk("m_out_rnd", out_rnd, m_words.size() != 0 ? m_words[0] : '0);
        chk("m_underflow", rnd_underflow, m_unf);
    endtask
    task automatic model_edge();
        bit ir, pop;
        if (flush) begin
            m_chunks.delete();
            m_words.delete();
            m_unf = 0;
        end else begin
            ir = m_ready();
            pop = out_ready && m_words.size() != 0;
            if (out_ready && m_words.size() == 0) m_unf = 1;
            if (pop) void'(m_words.pop_front());
            if (in_valid && ir) begin
                m_chunks.push_back(in_data);
                if (m_chunks.size() == K) begin
                    m_words.push_back(build_word());
                    m_chunks.delete();
                end
            end
        end
    endtask
    task automatic apply(input bit v, input logic [IN_W-1:0] d, input bit fl, input bit rdy);
        in_valid = v;
        in_data = d;
        flush = fl;
        out_ready = rdy;
        #1;
        check_model();
    endtask
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask
    function automatic void add(input bit v, input logic [IN_W-1:0] d, input bit fl, input bit rdy,
                                input bit e_ir, input bit e_ov, input int e_lvl, input bit e_unf);
        vec_t t;
        t.v = v; t.d = d; t.fl = fl; t.rdy = rdy;
        t.e_ir = e_ir; t.e_ov = e_ov; t.e_lvl = e_lvl; t.e_unf = e_unf;
        tbl.push_back(t);
    endfunction
    task automatic reset_check(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_level"}, level, 0);
        chk({tag, "_out_rnd"}, out_rnd, 0);
        chk({tag, "_underflow"}, rnd_underflow, 0);
    endtask
    task automatic run_random(input int n);
        for (int i = 0; i < n; i++) begin
            apply($urandom_range(0, 9) < 7, {$urandom, $urandom, $urandom, $urandom},
                  $urandom_range(0, 31) == 0, 1'($urandom_range(0, 1)));
            tick();
        end
    endtask
    initial begin
        logic [K*IN_W-1:0] tw;
        for (int i = 0; i < 17; i++) add(1, IN_W'(i + 1), 0, 0, 1, i >= 6, i >= 12 ? 2 : (i >= 6 ? 1 : 0), 0);
        add(1, 18, 0, 0, 0, 1, 2, 0);
        add(1, 18, 0, 1, 0, 1, 2, 0);
        add(1, 18, 0, 0, 1, 1, 1, 0);
        add(0, 0, 0, 0, 1, 1, 2, 0);
        add(0, 0, 1, 0, 1, 1, 2, 0);
        add(0, 0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 1);
        add(0, 0, 0, 1, 1, 0, 0, 1);
        add(0, 0, 1, 0, 1, 0, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0);
        in_valid = 0; in_data = '0; flush = 0; out_ready = 0;
        nrst = 1;
        #1 nrst = 0;
        #2 reset_check("rst");
        @(posedge clk); #1;
        nrst = 1;
        // six chunks form the first word, visible the cycle after the last one
        for (int i = 1; i <= 6; i++) begin apply(1, IN_W'(i), 0, 0); tick(); end
        apply(0, 0, 0, 0);
        chk("t2_valid", out_valid, 1);
        chk("t2_lo", out_rnd[127:0], 1);
        chk("t2_hi", out_rnd[679:640], 40'h6);
        tick();
        for (int i = 1; i <= 5; i++) begin apply(1, IN_W'('hA0 + i), 0, 0); tick(); end
        apply(1, 'hA6, 0, 1);
        chk("t6_level_pre", level, 1);
        chk("t6_old_word", out_rnd[127:0], 1);
        tick();
        apply(0, 0, 0, 0);
        chk("t6_level", level, 1);
        chk("t6_new_lo", out_rnd[127:0], 'hA1);
        chk("t6_new_hi", out_rnd[679:640], 40'hA6);
        tick();
        apply(0, 0, 0, 1); tick();
        apply(0, 0, 0, 0);
        chk("t6_drained", out_valid, 0);
        tick();
        for (int i = 0; i < 3; i++) begin apply(1, '1, 0, 0); tick(); end
        apply(1, '1, 1, 0);
        chk("t4_flush_ready", in_ready, 1);
        tick();
        apply(0, 0, 0, 0);
        chk("t4_level", level, 0);
        tick();
        for (int i = 1; i <= 5; i++) begin apply(1, IN_W'('hB0 + i), 0, 0); tick(); end
        apply(0, 0, 0, 0);
        chk("t4_not_yet", out_valid, 0);
        tick();
        apply(1, 'hB6, 0, 0); tick();
        apply(0, 0, 0, 0);
        for (int j = 0; j < K; j++) tw[j*IN_W +: IN_W] = IN_W'('hB1 + j);
        chk("t4_word", out_rnd, tw[OUT_W-1:0]);
        tick();
        apply(0, 0, 1, 0); tick();
        foreach (tbl[i]) begin
            apply(tbl[i].v, tbl[i].d, tbl[i].fl, tbl[i].rdy);
            chk($sformatf("tbl_ir[%0d]", i), in_ready, tbl[i].e_ir);
            chk($sformatf("tbl_ov[%0d]", i), out_valid, tbl[i].e_ov);
            chk($sformatf("tbl_lvl[%0d]", i), level, tbl[i].e_lvl);
            chk($sformatf("tbl_unf[%0d]", i), rnd_underflow, tbl[i].e_unf);
            tick();
        end
        run_random(1500);
        apply(1, '1, 0, 1);
        nrst = 0;
        #1 in_valid = 0; out_ready = 0;
        #1 reset_check("midrst");
        m_chunks.delete();
        m_words.delete();
        m_unf = 0;
        @(posedge clk); #1;
        nrst = 1;
        run_random(1500);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
